exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter A_WIDTH, default 5, SHALL set register address width; the register file has 2**A_WIDTH entries, and A_WIDTH >= 4.
REQ-002 Parameter D_WIDTH, default 32, SHALL set data width; D_WIDTH is a power of two >= 8.
REQ-003 Parameter MUL_EN, default 1, SHALL enable (1) or disable (0) the iterative multiply operation.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  an operation is presented this cycle.
REQ-007 in_ready  output  1  the unit can accept an operation this cycle.
REQ-008 ALUsrc  input  1  selects operand 2: 1 = ImmOp, 0 = register rs2.
REQ-009 ALUctrl  input  4  operation code, encoded per REQ-014.
REQ-010 RegWrite  input  1  writes the result to register rd.
REQ-011 rs1, rs2, rd  input  A_WIDTH each  source and destination register addresses.
REQ-012 ImmOp  input  D_WIDTH  immediate operand.
REQ-013 out_valid, EQ, ALUresult, a0  output  1/1/D_WIDTH/D_WIDTH:
- out_valid: one-cycle completion pulse.
- EQ: registered (op1 == op2) flag.
- ALUresult: registered result.
- a0: continuous contents of register 10.

Function
REQ-014 ALUctrl SHALL decode as follows:
- 0 add; 1 sub; 2 and; 3 or; 4 xor; 5 slt (signed); 6 sll; 7 srl; 8 sra; 9 sltu; 10 mul (low D_WIDTH bits of the product).
- Codes 11-15 SHALL produce result 0.
- When MUL_EN=0, code 10 SHALL also produce result 0.
REQ-015 Shift operations SHALL use only the low log2(D_WIDTH) bits of op2; slt and sltu SHALL produce a zero-extended 0 or 1.
REQ-016 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the inputs are ignored at all other times.
REQ-017 Register 0 SHALL always read as 0, and writes to it SHALL be discarded.
REQ-018 The FSM SHALL have two states, IDLE and MUL; in_ready SHALL be 1 only in IDLE.
REQ-019 A non-mul operation accepted in IDLE SHALL complete as follows:
- On the accept edge: ALUresult and EQ are registered, rd is written if RegWrite is 1, and out_valid is set to 1.
- out_valid is high exactly the cycle after accept; the FSM stays in IDLE.
REQ-020 Back-to-back non-mul operations SHALL be accepted every cycle; an operation reading the rd written on the previous edge SHALL see the new value.
REQ-021 An accepted mul (MUL_EN=1) SHALL behave as follows:
- At accept: op1, op2, rd and RegWrite are latched, EQ is registered, and the FSM enters MUL.
- The multiplier performs one shift-add step per cycle for D_WIDTH cycles.
- On the D_WIDTH-th MUL edge: ALUresult is registered, rd is written if the latched RegWrite is 1, out_valid is set, and the FSM returns to IDLE.
- Total latency from accept to out_valid is D_WIDTH+1 cycles.
REQ-022 During MUL, in_valid SHALL be ignored, no register file write SHALL occur, and ALUresult and EQ SHALL hold their previous values.
REQ-023 Arithmetic SHALL wrap modulo 2**D_WIDTH, with no overflow indication.
REQ-024 out_valid SHALL be 0 in every cycle that does not immediately follow a completion edge.

Reset
REQ-025 While rst is 1, regardless of clk, the unit SHALL hold:
- FSM in IDLE; in_ready = 1;
- out_valid = 0, EQ = 0, ALUresult = 0;
- all registers = 0, so a0 = 0;
- the multiplier accumulator and counter cleared.
REQ-026 Reset asserted during MUL SHALL abort the multiply, with no register write and no out_valid pulse.
REQ-027 The first operation SHALL be accepted on the first rising edge after rst is deasserted.

Verification
REQ-028 Reset, then add x10 = x0 + imm 5 (ALUsrc=1, rd=10) -> next cycle: out_valid = 1, ALUresult = 5, a0 = 5.
REQ-029 Back-to-back add x1 = x0 + 7, then sub x2 = x1 - imm 9 -> ALUresult 7, then 0xFFFFFFFE on consecutive cycles; EQ = 0 for both.
REQ-030 Write to rd=0 with value 3, then read x0 -> reads 0; sra of 0x80000000 by imm 33 -> 0xC0000000 (shift amount is 1).
REQ-031 mul x3 = 0x10001 * 0x10001 -> in_ready = 0 for 32 cycles, out_valid 33 cycles after accept, ALUresult = 0x00020001; in_valid pulses during MUL are ignored.
REQ-032 Reset asserted 10 cycles into a mul to x3 -> x3 remains 0, no out_valid pulse, in_ready = 1 during reset.
REQ-033 MUL_EN=0 build: code 10 with RegWrite=1 -> single-cycle completion, ALUresult = 0.

Source files
------------

// File: rtl/exec_unit_if.sv
// Operation request / completion bundle between a sequencer and exec_unit.
// The master issues operations; the slave (exec_unit) reports results.
interface exec_unit_if #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic               ALUsrc;
    logic [3:0]         ALUctrl;
    logic               RegWrite;
    logic [A_WIDTH-1:0] rs1;
    logic [A_WIDTH-1:0] rs2;
    logic [A_WIDTH-1:0] rd;
    logic [D_WIDTH-1:0] ImmOp;
    logic               out_valid;
    logic               EQ;
    logic [D_WIDTH-1:0] ALUresult;
    logic [D_WIDTH-1:0] a0;

    modport master (
        output in_valid, ALUsrc, ALUctrl, RegWrite, rs1, rs2, rd, ImmOp,
        input  in_ready, out_valid, EQ, ALUresult, a0
    );

    modport slave (
        input  in_valid, ALUsrc, ALUctrl, RegWrite, rs1, rs2, rd, ImmOp,
        output in_ready, out_valid, EQ, ALUresult, a0
    );
endinterface

// File: rtl/exec_unit.sv
// Register file plus ALU: single-cycle ops complete on the accept edge,
// mul runs as a D_WIDTH-step shift-add sequence with the unit stalled.
module exec_unit #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32,
    parameter int MUL_EN  = 1
) (
    input logic         clk,
    input logic         rst,
    exec_unit_if.slave  bus
);
    localparam int SH_W = $clog2(D_WIDTH);
    localparam int REGS = 1 << A_WIDTH;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_next;
    logic [D_WIDTH-1:0] regs [REGS];
    logic [D_WIDTH-1:0] op1, op2, alu_res;
    logic [D_WIDTH-1:0] mcand, mplier, acc, acc_step;
    logic [SH_W-1:0]    cnt;
    logic [A_WIDTH-1:0] mul_rd;
    logic               mul_we;
    logic               accept, start_mul, mul_done;
    logic               wr_en;
    logic [A_WIDTH-1:0] wr_addr;
    logic [D_WIDTH-1:0] wr_data;

    function automatic logic [D_WIDTH-1:0] alu(input logic [3:0] ctrl,
                                               input logic [D_WIDTH-1:0] a,
                                               input logic [D_WIDTH-1:0] b);
        logic signed [D_WIDTH-1:0] sa;
        logic signed [D_WIDTH-1:0] sb;
        logic [SH_W-1:0]           sh;
        logic [D_WIDTH-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        case (ctrl)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = {{(D_WIDTH-1){1'b0}}, sa < sb};
            4'd6:    r = a << sh;
            4'd7:    r = a >> sh;
            4'd8:    r = sa >>> sh;
            4'd9:    r = {{(D_WIDTH-1){1'b0}}, a < b};
            default: r = '0;  // mul is produced by the iterative path only
        endcase
        return r;
    endfunction

    assign op1       = (bus.rs1 == '0) ? '0 : regs[bus.rs1];
    assign op2       = bus.ALUsrc ? bus.ImmOp : ((bus.rs2 == '0) ? '0 : regs[bus.rs2]);
    assign alu_res   = alu(bus.ALUctrl, op1, op2);
    assign accept    = bus.in_valid && bus.in_ready;
    assign start_mul = accept && (MUL_EN != 0) && (bus.ALUctrl == OP_MUL);
    assign acc_step  = acc + (mplier[0] ? mcand : '0);
    assign mul_done  = (state == MUL) && (cnt == SH_W'(D_WIDTH - 1));
    assign bus.a0    = regs[A_WIDTH'(10)];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.rd;
        wr_data = alu_res;
        if (accept && !start_mul && bus.RegWrite && (bus.rd != '0)) begin
            wr_en = 1'b1;
        end else if (mul_done && mul_we && (mul_rd != '0)) begin
            wr_en   = 1'b1;
            wr_addr = mul_rd;
            wr_data = acc_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (start_mul) state_next = MUL;
            end
            MUL: begin
                if (mul_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Accept edge: single-cycle result or multiplier load; MUL edges: one shift-add step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.EQ        <= 1'b0;
            bus.ALUresult <= '0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
            mul_rd        <= '0;
            mul_we        <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (accept) begin
                bus.EQ <= (op1 == op2);
                if (start_mul) begin
                    mcand  <= op1;
                    mplier <= op2;
                    acc    <= '0;
                    cnt    <= '0;
                    mul_rd <= bus.rd;
                    mul_we <= bus.RegWrite;
                end else begin
                    bus.ALUresult <= alu_res;
                    bus.out_valid <= 1'b1;
                end
            end else if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_done) begin
                    bus.ALUresult <= acc_step;
                    bus.out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a MUL_EN=1 instance for the main scenarios
// and a MUL_EN=0 instance for the disabled-multiply build.
module tb_exec_unit;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_BAD = 4'd11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exec_unit_if #(.A_WIDTH(5), .D_WIDTH(32)) bus ();
    exec_unit_if #(.A_WIDTH(5), .D_WIDTH(32)) bus0 ();

    exec_unit #(.A_WIDTH(5), .D_WIDTH(32), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    exec_unit #(.A_WIDTH(5), .D_WIDTH(32), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    // Presents one operation, waits for its accept edge, then samples 1 time unit later.
    task automatic drive(input logic [3:0] ctrl, input logic src, input logic wr,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic [31:0] imm);
        bus.in_valid = 1'b1; bus.ALUctrl = ctrl; bus.ALUsrc = src; bus.RegWrite = wr;
        bus.rs1 = a; bus.rs2 = b; bus.rd = d; bus.ImmOp = imm;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drive0(input logic [3:0] ctrl, input logic src, input logic wr,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input logic [31:0] imm);
        bus0.in_valid = 1'b1; bus0.ALUctrl = ctrl; bus0.ALUsrc = src; bus0.RegWrite = wr;
        bus0.rs1 = a; bus0.rs2 = b; bus0.rd = d; bus0.ImmOp = imm;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.EQ !== 1'b0) begin failures++; $display("FAIL reset_eq got=%b want=0", bus.EQ); end
        checks++; if (bus.ALUresult !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", bus.ALUresult); end
        checks++; if (bus.a0 !== 32'h0) begin failures++; $display("FAIL reset_a0 got=%h want=0", bus.a0); end
        rst = 1'b0;
    endtask

    task automatic test_add_a0();
        drive(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 32'd5);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b want=1", bus.out_valid); end
        checks++; if (bus.ALUresult !== 32'd5) begin failures++; $display("FAIL add_result got=%h want=%h", bus.ALUresult, 32'd5); end
        checks++; if (bus.a0 !== 32'd5) begin failures++; $display("FAIL add_a0 got=%h want=%h", bus.a0, 32'd5); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 32'd7);
        checks++; if (bus.ALUresult !== 32'd7 || bus.out_valid !== 1'b1 || bus.EQ !== 1'b0) begin
            failures++; $display("FAIL b2b_add got=%h/%b/%b want=00000007/1/0", bus.ALUresult, bus.out_valid, bus.EQ); end
        drive(OP_SUB, 1'b1, 1'b1, 5'd1, 5'd0, 5'd2, 32'd9);
        checks++; if (bus.ALUresult !== 32'hFFFF_FFFE || bus.out_valid !== 1'b1 || bus.EQ !== 1'b0) begin
            failures++; $display("FAIL b2b_sub got=%h/%b/%b want=fffffffe/1/0", bus.ALUresult, bus.out_valid, bus.EQ); end
        drive(OP_ADD, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0);
        checks++; if (bus.ALUresult !== 32'd5) begin failures++; $display("FAIL rr_add got=%h want=%h", bus.ALUresult, 32'd5); end
        drive(OP_XOR, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
        checks++; if (bus.ALUresult !== 32'd0 || bus.EQ !== 1'b1) begin
            failures++; $display("FAIL xor_eq got=%h/%b want=00000000/1", bus.ALUresult, bus.EQ); end
    endtask

    task automatic test_x0_and_shifts();
        drive(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'd3);
        checks++; if (bus.ALUresult !== 32'd3) begin failures++; $display("FAIL x0_write_result got=%h want=%h", bus.ALUresult, 32'd3); end
        drive(OP_ADD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        checks++; if (bus.ALUresult !== 32'd0 || bus.EQ !== 1'b1) begin
            failures++; $display("FAIL x0_read got=%h/%b want=00000000/1", bus.ALUresult, bus.EQ); end
        drive(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd6, 32'h8000_0000);
        drive(OP_SRA, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd33);
        checks++; if (bus.ALUresult !== 32'hC000_0000) begin failures++; $display("FAIL sra got=%h want=c0000000", bus.ALUresult); end
        drive(OP_SRL, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd33);
        checks++; if (bus.ALUresult !== 32'h4000_0000) begin failures++; $display("FAIL srl got=%h want=40000000", bus.ALUresult); end
        drive(OP_SLL, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd36);
        checks++; if (bus.ALUresult !== 32'h70) begin failures++; $display("FAIL sll got=%h want=00000070", bus.ALUresult); end
        drive(OP_SLT, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd1);
        checks++; if (bus.ALUresult !== 32'd1) begin failures++; $display("FAIL slt got=%h want=00000001", bus.ALUresult); end
        drive(OP_SLTU, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd1);
        checks++; if (bus.ALUresult !== 32'd0) begin failures++; $display("FAIL sltu got=%h want=00000000", bus.ALUresult); end
        drive(OP_AND, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'hFFFF_FFFF);
        checks++; if (bus.ALUresult !== 32'h8000_0000) begin failures++; $display("FAIL and got=%h want=80000000", bus.ALUresult); end
        drive(OP_BAD, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 32'd5);
        checks++; if (bus.ALUresult !== 32'd0 || bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL unused_code got=%h/%b want=00000000/1", bus.ALUresult, bus.out_valid); end
    endtask

    task automatic test_mul();
        drive(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 32'h0001_0001);
        drive(OP_MUL, 1'b1, 1'b1, 5'd4, 5'd0, 5'd3, 32'h0001_0001);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.EQ !== 1'b1) begin
            failures++; $display("FAIL mul_accept ready/ov/eq got=%b/%b/%b want=0/0/1", bus.in_ready, bus.out_valid, bus.EQ); end
        // Intruding write to x3 is held on in_valid for the whole multiply
        bus.in_valid = 1'b1; bus.ALUctrl = OP_ADD; bus.ALUsrc = 1'b1; bus.RegWrite = 1'b1;
        bus.rs1 = 5'd0; bus.rd = 5'd3; bus.ImmOp = 32'd99;
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.ALUresult !== 32'h0001_0001) begin
                failures++; $display("FAIL mul_busy cycle=%0d ready/ov/result got=%b/%b/%h want=0/0/00010001", i, bus.in_ready, bus.out_valid, bus.ALUresult); end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.ALUresult !== 32'h0002_0001 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL mul_done ov/result/ready got=%b/%h/%b want=1/00020001/1", bus.out_valid, bus.ALUresult, bus.in_ready); end
        drive(OP_ADD, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0);
        checks++; if (bus.ALUresult !== 32'h0002_0001) begin failures++; $display("FAIL mul_x3 got=%h want=00020001", bus.ALUresult); end
    endtask

    task automatic test_reset_during_mul();
        logic seen;
        drive(OP_MUL, 1'b1, 1'b1, 5'd4, 5'd0, 5'd3, 32'd3);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.ALUresult !== 32'd0 || bus.a0 !== 32'd0) begin
            failures++; $display("FAIL async_reset ready/ov/result/a0 got=%b/%b/%h/%h want=1/0/0/0", bus.in_ready, bus.out_valid, bus.ALUresult, bus.a0); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_hold_ready got=%b want=1", bus.in_ready); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL aborted_mul_pulse got=%b want=0", seen); end
        drive(OP_ADD, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd0);
        checks++; if (bus.ALUresult !== 32'd0 || bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL aborted_mul_x3 got=%h/%b want=00000000/1", bus.ALUresult, bus.out_valid); end
    endtask

    task automatic test_mul_disabled();
        drive0(OP_ADD, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'd6);
        checks++; if (bus0.ALUresult !== 32'd6) begin failures++; $display("FAIL nomul_load got=%h want=00000006", bus0.ALUresult); end
        drive0(OP_MUL, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 32'd7);
        checks++; if (bus0.out_valid !== 1'b1 || bus0.ALUresult !== 32'd0 || bus0.in_ready !== 1'b1 || bus0.EQ !== 1'b0) begin
            failures++; $display("FAIL nomul_op ov/result/ready/eq got=%b/%h/%b/%b want=1/0/1/0", bus0.out_valid, bus0.ALUresult, bus0.in_ready, bus0.EQ); end
        drive0(OP_ADD, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
        checks++; if (bus0.ALUresult !== 32'd0) begin failures++; $display("FAIL nomul_x5 got=%h want=00000000", bus0.ALUresult); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.ALUsrc = 1'b0; bus.ALUctrl = 4'd0; bus.RegWrite = 1'b0;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.ImmOp = '0;
        bus0.in_valid = 1'b0; bus0.ALUsrc = 1'b0; bus0.ALUctrl = 4'd0; bus0.RegWrite = 1'b0;
        bus0.rs1 = '0; bus0.rs2 = '0; bus0.rd = '0; bus0.ImmOp = '0;
        test_reset();
        test_add_a0();
        test_back_to_back();
        test_x0_and_shifts();
        test_mul();
        test_reset_during_mul();
        test_mul_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
